// File: rtl/aux_id_stage.sv
`default_nettype none
//==============================================================================
// Module      : aux_id_stage
// Description : ID-stage auxiliary logic with a registered ID/EX output.
//               Selects the destination register, extends the immediate,
//               holds the result behind a valid/ready handshake, stalls one
//               cycle on a load-use hazard and counts the inserted bubbles.
// Revision    : 1.0 - initial release
//==============================================================================
module aux_id_stage #(
    parameter int GPR_BIT  = 32,
    parameter int GPR_ADR  = 5,
    parameter int IMM_BIT  = 16,
    parameter int LINK_REG = 31,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst_n,

    // Decoded instruction from ID
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [GPR_ADR-1:0] in_rs,
    input  logic [GPR_ADR-1:0] in_rt,
    input  logic [GPR_ADR-1:0] in_rd,
    input  logic               in_use_rs,
    input  logic               in_use_rt,
    input  logic [IMM_BIT-1:0] in_imm,
    input  logic [1:0]         in_ext_mode,
    input  logic [1:0]         in_dst_mode,
    input  logic               in_is_load,

    input  logic               flush,

    // Registered instruction towards EX
    output logic               out_valid,
    input  logic               out_ready,
    output logic [GPR_ADR-1:0] out_dst,
    output logic               out_wr_en,
    output logic [GPR_BIT-1:0] out_ext_imm,
    output logic               out_is_load,

    output logic [CNT_W-1:0]   bubble_cnt
);

    // Number of bits the raw immediate is padded by when widened
    localparam int c_pad_bits = GPR_BIT - IMM_BIT;

    // Immediate extension modes
    localparam logic [1:0] c_ext_sext      = 2'd0;
    localparam logic [1:0] c_ext_zext      = 2'd1;
    localparam logic [1:0] c_ext_upper     = 2'd2;
    localparam logic [1:0] c_ext_sext_shl2 = 2'd3;

    // Destination select modes
    localparam logic [1:0] c_dst_rt   = 2'd0;
    localparam logic [1:0] c_dst_rd   = 2'd1;
    localparam logic [1:0] c_dst_link = 2'd2;
    localparam logic [1:0] c_dst_none = 2'd3;

    localparam logic [GPR_ADR-1:0] c_link_reg = GPR_ADR'(LINK_REG);
    localparam logic [GPR_ADR-1:0] c_zero_reg = '0;

    //--------------------------------------------------------------------------
    // Pipeline register contents
    //--------------------------------------------------------------------------
    logic               r_valid;
    logic [GPR_ADR-1:0] r_dst;
    logic               r_wr_en;
    logic [GPR_BIT-1:0] r_ext_imm;
    logic               r_is_load;
    logic [CNT_W-1:0]   r_bubble_cnt;

    //--------------------------------------------------------------------------
    // Combinational datapath
    //--------------------------------------------------------------------------
    logic [GPR_BIT-1:0] w_sext;
    logic [GPR_BIT-1:0] w_zext;
    logic [GPR_BIT-1:0] w_upper;
    logic [GPR_BIT-1:0] w_sext_shl2;
    logic [GPR_BIT-1:0] w_ext_imm;
    logic [GPR_ADR-1:0] w_dst;
    logic               w_wr_en;

    assign w_sext      = {{c_pad_bits{in_imm[IMM_BIT-1]}}, in_imm};
    assign w_zext      = {{c_pad_bits{1'b0}}, in_imm};
    assign w_upper     = {in_imm, {c_pad_bits{1'b0}}};
    // Shift drops the two top bits of the sign-extended value (mod 2^GPR_BIT)
    assign w_sext_shl2 = {w_sext[GPR_BIT-3:0], 2'b00};

    // Pick the immediate form requested by the decoder
    always_comb begin
        w_ext_imm = w_sext;
        case (in_ext_mode)
            c_ext_sext:      w_ext_imm = w_sext;
            c_ext_zext:      w_ext_imm = w_zext;
            c_ext_upper:     w_ext_imm = w_upper;
            c_ext_sext_shl2: w_ext_imm = w_sext_shl2;
            default:         w_ext_imm = w_sext;
        endcase
    end

    // Pick the destination register address
    always_comb begin
        w_dst = c_zero_reg;
        case (in_dst_mode)
            c_dst_rt:   w_dst = in_rt;
            c_dst_rd:   w_dst = in_rd;
            c_dst_link: w_dst = c_link_reg;
            c_dst_none: w_dst = c_zero_reg;
            default:    w_dst = c_zero_reg;
        endcase
    end

    // r0 is hard-wired, so a write to it is suppressed; this also keeps
    // r0 out of hazard detection.
    assign w_wr_en = (in_dst_mode != c_dst_none) && (w_dst != c_zero_reg);

    //--------------------------------------------------------------------------
    // Load-use hazard and handshake
    //--------------------------------------------------------------------------
    logic w_rs_hit;
    logic w_rt_hit;
    logic w_hazard;
    logic w_take;
    logic w_bubble;
    logic w_drain;
    logic w_cnt_full;

    assign w_rs_hit = in_use_rs && (in_rs == r_dst);
    assign w_rt_hit = in_use_rt && (in_rt == r_dst);
    assign w_hazard = r_valid && r_is_load && r_wr_en && (w_rs_hit || w_rt_hit);

    // No skid buffer: acceptance follows out_ready in the same cycle.
    // Gated by rst_n so nothing is accepted while reset is asserted.
    assign in_ready = rst_n && !flush && !w_hazard && (!r_valid || out_ready);

    assign w_take   = in_valid && in_ready;
    // A bubble is only real once EX takes the load; flush overrides it
    assign w_bubble = !flush && w_hazard && in_valid && out_ready;
    assign w_drain  = r_valid && out_ready;

    assign w_cnt_full = &r_bubble_cnt;

    //--------------------------------------------------------------------------
    // Sequential state
    //--------------------------------------------------------------------------

    // Valid flag: flush, then accept, then bubble/drain empty the stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_take) begin
            r_valid <= 1'b1;
        end else if (w_bubble || w_drain) begin
            r_valid <= 1'b0;
        end
    end

    // Payload registers load only on an accepted transfer, so they hold
    // steady while EX back-pressures.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dst     <= '0;
            r_wr_en   <= 1'b0;
            r_ext_imm <= '0;
            r_is_load <= 1'b0;
        end else if (!flush && w_take) begin
            r_dst     <= w_dst;
            r_wr_en   <= w_wr_en;
            r_ext_imm <= w_ext_imm;
            r_is_load <= in_is_load;
        end
    end

    // Saturating bubble counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bubble_cnt <= '0;
        end else if (w_bubble && !w_cnt_full) begin
            r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
        end
    end

    //--------------------------------------------------------------------------
    // Outputs
    //--------------------------------------------------------------------------
    assign out_valid   = r_valid;
    assign out_dst     = r_dst;
    assign out_wr_en   = r_wr_en;
    assign out_ext_imm = r_ext_imm;
    assign out_is_load = r_is_load;
    assign bubble_cnt  = r_bubble_cnt;

endmodule
`default_nettype wire

// File: tb/tb_aux_id_stage.sv
`default_nettype none
//==============================================================================
// Module      : tb_aux_id_stage
// Description : Self-checking bench for aux_id_stage (CNT_W=2 so the
//               bubble counter saturates quickly).
// Revision    : 1.0 - initial release
//==============================================================================
module tb_aux_id_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic        in_use_rs;
    logic        in_use_rt;
    logic [15:0] in_imm;
    logic [1:0]  in_ext_mode;
    logic [1:0]  in_dst_mode;
    logic        in_is_load;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_dst;
    logic        out_wr_en;
    logic [31:0] out_ext_imm;
    logic        out_is_load;
    logic [1:0]  bubble_cnt;

    int n_pass;
    int n_total;

    aux_id_stage #(
        .GPR_BIT  (32),
        .GPR_ADR  (5),
        .IMM_BIT  (16),
        .LINK_REG (31),
        .CNT_W    (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_rs       (in_rs),
        .in_rt       (in_rt),
        .in_rd       (in_rd),
        .in_use_rs   (in_use_rs),
        .in_use_rt   (in_use_rt),
        .in_imm      (in_imm),
        .in_ext_mode (in_ext_mode),
        .in_dst_mode (in_dst_mode),
        .in_is_load  (in_is_load),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_dst     (out_dst),
        .out_wr_en   (out_wr_en),
        .out_ext_imm (out_ext_imm),
        .out_is_load (out_is_load),
        .bubble_cnt  (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    //--------------------------------------------------------------------------
    // Reference model: the stage seen as a one-entry queue
    //--------------------------------------------------------------------------
    logic        m_valid;
    logic [4:0]  m_dst;
    logic        m_wr;
    logic [31:0] m_imm;
    logic        m_load;
    int          m_cnt;

    function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [1:0] mode);
        longint      v;
        logic [63:0] t;
        v = longint'(imm);
        if (imm >= 16'h8000) v = v - 65536;
        case (mode)
            2'd0:    t = 64'(v);
            2'd1:    t = 64'(imm);
            2'd2:    t = 64'(longint'(imm) * 65536);
            default: t = 64'(v * 4);
        endcase
        return t[31:0];
    endfunction

    function automatic logic [4:0] ref_dst(input logic [1:0] mode, input logic [4:0] rt,
                                           input logic [4:0] rd);
        case (mode)
            2'd0:    return rt;
            2'd1:    return rd;
            2'd2:    return 5'd31;
            default: return 5'd0;
        endcase
    endfunction

    function automatic logic ref_hazard();
        if (!(m_valid && m_load && m_wr)) return 1'b0;
        return (in_use_rs && in_rs == m_dst) || (in_use_rt && in_rt == m_dst);
    endfunction

    function automatic logic ref_ready();
        return rst_n && !flush && !ref_hazard() && (!m_valid || out_ready);
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_dst = '0; m_wr = 1'b0; m_imm = '0; m_load = 1'b0; m_cnt = 0;
    endtask

    // Advance one clock; the model steps at the same edge as the DUT
    task automatic tick();
        logic        nv, nw, nl;
        logic [4:0]  nd;
        logic [31:0] ni;
        int          nc;
        nv = m_valid; nd = m_dst; nw = m_wr; ni = m_imm; nl = m_load; nc = m_cnt;
        if (!rst_n) begin
            nv = 0; nd = 0; nw = 0; ni = 0; nl = 0; nc = 0;
        end else if (flush) begin
            nv = 0;
        end else if (in_valid && ref_ready()) begin
            nv = 1;
            nd = ref_dst(in_dst_mode, in_rt, in_rd);
            nw = (in_dst_mode != 2'd3) && (nd != 0);
            ni = ref_ext(in_imm, in_ext_mode);
            nl = in_is_load;
        end else if (ref_hazard() && in_valid && out_ready) begin
            nv = 0;
            nc = (m_cnt < 3) ? m_cnt + 1 : 3;
        end else if (m_valid && out_ready) begin
            nv = 0;
        end
        @(posedge clk);
        m_valid = nv; m_dst = nd; m_wr = nw; m_imm = ni; m_load = nl; m_cnt = nc;
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_rs = 0; in_rt = 0; in_rd = 0; in_use_rs = 0; in_use_rt = 0;
        in_imm = 0; in_ext_mode = 0; in_dst_mode = 0; in_is_load = 0; flush = 0;
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic urs, input logic urt, input logic [15:0] imm,
                         input logic [1:0] em, input logic [1:0] dm, input logic ld);
        in_valid = 1; in_rs = rs; in_rt = rt; in_rd = rd; in_use_rs = urs; in_use_rt = urt;
        in_imm = imm; in_ext_mode = em; in_dst_mode = dm; in_is_load = ld;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        idle_inputs();
        out_ready = 1;
        rst_n = 0;
        model_reset();
        tick();
        tick();
        rst_n = 1;
    endtask

    //--------------------------------------------------------------------------
    // Tests
    //--------------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 0;
        idle_inputs();
        in_valid = 1; out_ready = 1;
        model_reset();
        tick();
        n_total++;
        if (out_valid !== 1'b0 || out_dst !== 5'd0 || out_wr_en !== 1'b0 ||
            out_ext_imm !== 32'd0 || out_is_load !== 1'b0 || bubble_cnt !== 2'd0)
            $display("FAIL reset_outputs: got v=%b d=%0d w=%b i=%h l=%b c=%0d required all 0",
                     out_valid, out_dst, out_wr_en, out_ext_imm, out_is_load, bubble_cnt);
        else n_pass++;
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b required 0", in_ready);
        else n_pass++;
        idle_inputs();
        tick();
        rst_n = 1;
    endtask

    task automatic test_ext_modes();
        logic [31:0] exp_imm [4];
        exp_imm[0] = 32'hFFFF8001; exp_imm[1] = 32'h00008001;
        exp_imm[2] = 32'h80010000; exp_imm[3] = 32'hFFFE0004;
        do_reset();
        for (int m = 0; m < 4; m++) begin
            drive(0, 0, 1, 0, 0, 16'h8001, 2'(m), 2'd1, 0);
            tick();
            n_total++;
            if (out_valid !== 1'b1 || out_ext_imm !== exp_imm[m])
                $display("FAIL ext_mode%0d: got v=%b imm=%h required v=1 imm=%h",
                         m, out_valid, out_ext_imm, exp_imm[m]);
            else n_pass++;
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_dst_select();
        logic [4:0] exp_d [5];
        logic       exp_w [5];
        logic [4:0] rt_v  [5];
        logic [1:0] dm_v  [5];
        exp_d[0] = 5;  exp_w[0] = 1; rt_v[0] = 5; dm_v[0] = 0;
        exp_d[1] = 9;  exp_w[1] = 1; rt_v[1] = 5; dm_v[1] = 1;
        exp_d[2] = 31; exp_w[2] = 1; rt_v[2] = 5; dm_v[2] = 2;
        exp_d[3] = 0;  exp_w[3] = 0; rt_v[3] = 5; dm_v[3] = 3;
        exp_d[4] = 0;  exp_w[4] = 0; rt_v[4] = 0; dm_v[4] = 0;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive(0, rt_v[k], 9, 0, 0, 16'h0, 0, dm_v[k], 0);
            tick();
            n_total++;
            if (out_valid !== 1'b1 || out_dst !== exp_d[k] || out_wr_en !== exp_w[k])
                $display("FAIL dst_case%0d: got v=%b d=%0d w=%b required v=1 d=%0d w=%b",
                         k, out_valid, out_dst, out_wr_en, exp_d[k], exp_w[k]);
            else n_pass++;
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_hazard();
        do_reset();
        drive(0, 7, 0, 0, 0, 16'h0, 0, 2'd0, 1);   // load r7
        tick();
        drive(7, 0, 3, 1, 0, 16'h0, 0, 2'd1, 0);   // reads r7, writes r3
        #1;
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL hazard_stall: got in_ready=%b required 0", in_ready);
        else n_pass++;
        tick();
        n_total++;
        if (out_valid !== 1'b0 || bubble_cnt !== 2'd1)
            $display("FAIL hazard_bubble: got v=%b cnt=%0d required v=0 cnt=1", out_valid, bubble_cnt);
        else n_pass++;
        #1;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL hazard_release: got in_ready=%b required 1", in_ready);
        else n_pass++;
        tick();
        n_total++;
        if (out_valid !== 1'b1 || out_dst !== 5'd3 || bubble_cnt !== 2'd1)
            $display("FAIL hazard_dependent: got v=%b d=%0d cnt=%0d required v=1 d=3 cnt=1",
                     out_valid, out_dst, bubble_cnt);
        else n_pass++;
        idle_inputs();
        tick();
    endtask

    task automatic test_no_hazard();
        for (int k = 0; k < 2; k++) begin
            do_reset();
            // k=0: consumer does not read rs; k=1: load targets r0
            drive(0, (k == 0) ? 5'd7 : 5'd0, 0, 0, 0, 16'h0, 0, 2'd0, 1);
            tick();
            drive((k == 0) ? 5'd7 : 5'd0, 0, 3, (k == 0) ? 1'b0 : 1'b1, 0, 16'h0, 0, 2'd1, 0);
            #1;
            n_total++;
            if (in_ready !== 1'b1) $display("FAIL nohaz%0d_ready: got %b required 1", k, in_ready);
            else n_pass++;
            tick();
            n_total++;
            if (out_valid !== 1'b1 || out_dst !== 5'd3 || bubble_cnt !== 2'd0)
                $display("FAIL nohaz%0d_next: got v=%b d=%0d cnt=%0d required v=1 d=3 cnt=0",
                         k, out_valid, out_dst, bubble_cnt);
            else n_pass++;
            idle_inputs();
            tick();
        end
    endtask

    task automatic test_stall_flush();
        do_reset();
        drive(0, 0, 9, 0, 0, 16'h1234, 2'd1, 2'd1, 1);
        tick();
        out_ready = 0;
        drive(0, 0, 4, 0, 0, 16'h5555, 2'd1, 2'd1, 0);
        for (int c = 0; c < 3; c++) begin
            #1;
            n_total++;
            if (in_ready !== 1'b0) $display("FAIL stall%0d_ready: got %b required 0", c, in_ready);
            else n_pass++;
            tick();
            n_total++;
            if (out_valid !== 1'b1 || out_dst !== 5'd9 || out_wr_en !== 1'b1 ||
                out_ext_imm !== 32'h00001234 || out_is_load !== 1'b1)
                $display("FAIL stall%0d_hold: got v=%b d=%0d w=%b i=%h l=%b required v=1 d=9 w=1 i=00001234 l=1",
                         c, out_valid, out_dst, out_wr_en, out_ext_imm, out_is_load);
            else n_pass++;
        end
        flush = 1;
        tick();
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL flush_clear: got v=%b required 0", out_valid);
        else n_pass++;
        flush = 0;
        in_valid = 0;
        out_ready = 1;
        tick();
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL flush_drop: got v=%b required 0", out_valid);
        else n_pass++;
    endtask

    task automatic test_saturate_async_reset();
        do_reset();
        for (int h = 0; h < 5; h++) begin
            drive(0, 7, 0, 0, 0, 16'h0, 0, 2'd0, 1);
            tick();
            drive(0, 7, 0, 0, 1, 16'h0, 0, 2'd3, 0);   // reads r7 via rt
            tick();
            tick();
            idle_inputs();
            tick();
            n_total++;
            if (bubble_cnt !== 2'((h + 1 > 3) ? 3 : h + 1))
                $display("FAIL sat_cnt%0d: got %0d required %0d", h, bubble_cnt, (h + 1 > 3) ? 3 : h + 1);
            else n_pass++;
        end
        drive(0, 0, 12, 0, 0, 16'hBEEF, 2'd0, 2'd1, 1);
        tick();
        in_valid = 1;
        #2;
        rst_n = 0;          // mid-cycle, no clock edge in between
        model_reset();
        #1;
        n_total++;
        if (out_valid !== 1'b0 || out_dst !== 5'd0 || out_wr_en !== 1'b0 ||
            out_ext_imm !== 32'd0 || out_is_load !== 1'b0 || bubble_cnt !== 2'd0 || in_ready !== 1'b0)
            $display("FAIL async_reset: got v=%b d=%0d w=%b i=%h l=%b c=%0d r=%b required all 0",
                     out_valid, out_dst, out_wr_en, out_ext_imm, out_is_load, bubble_cnt, in_ready);
        else n_pass++;
        idle_inputs();
        tick();
        rst_n = 1;
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            in_rs       = 5'($urandom_range(0, 3));
            in_rt       = 5'($urandom_range(0, 3));
            in_rd       = 5'($urandom_range(0, 3));
            in_use_rs   = 1'($urandom_range(0, 1));
            in_use_rt   = 1'($urandom_range(0, 1));
            in_imm      = 16'($urandom);
            in_ext_mode = 2'($urandom_range(0, 3));
            in_dst_mode = 2'($urandom_range(0, 3));
            in_is_load  = ($urandom_range(0, 2) != 0);
            flush       = ($urandom_range(0, 15) == 0);
            out_ready   = ($urandom_range(0, 3) != 0);
            #1;
            n_total++;
            if (in_ready !== ref_ready()) begin
                $display("FAIL rand_ready@%0d: got %b required %b", c, in_ready, ref_ready());
                errs++;
            end else n_pass++;
            tick();
            n_total++;
            if (out_valid !== m_valid || bubble_cnt !== 2'(m_cnt) ||
                (m_valid && (out_dst !== m_dst || out_wr_en !== m_wr ||
                             out_ext_imm !== m_imm || out_is_load !== m_load))) begin
                $display("FAIL rand_out@%0d: got v=%b d=%0d w=%b i=%h l=%b c=%0d required v=%b d=%0d w=%b i=%h l=%b c=%0d",
                         c, out_valid, out_dst, out_wr_en, out_ext_imm, out_is_load, bubble_cnt,
                         m_valid, m_dst, m_wr, m_imm, m_load, m_cnt);
                errs++;
            end else n_pass++;
            if (errs > 10) break;
        end
        idle_inputs();
        out_ready = 1;
        tick();
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_n   = 0;
        out_ready = 0;
        idle_inputs();
        model_reset();
        test_reset();
        test_ext_modes();
        test_dst_select();
        test_hazard();
        test_no_hazard();
        test_stall_flush();
        test_saturate_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aux_id_stage.md
Name: aux_id_stage

Overview:
- Parametrised, registered successor to the ID-stage auxiliary logic.
- Selects the destination register (rt / rd / link / none) and extends the immediate in one of four modes.
- Holds the results in an ID/EX pipeline register with a valid/ready handshake and a flush input.
- Detects load-use hazards against the instruction held in that register, inserts exactly one bubble per hazard, and counts bubbles in a saturating counter.

Parameters:
- GPR_BIT, 32, datapath / GPR width
- GPR_ADR, 5, register address width
- IMM_BIT, 16, raw immediate width (must be < GPR_BIT - 2)
- LINK_REG, 31, register written by dst_mode=LINK
- CNT_W, 16, bubble counter width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage accepts the input this cycle
- in_rs  in  GPR_ADR  source reg 1
- in_rt  in  GPR_ADR  source reg 2 / alternate destination
- in_rd  in  GPR_ADR  destination
- in_use_rs  in  1  instruction reads rs
- in_use_rt  in  1  instruction reads rt
- in_imm  in  IMM_BIT  raw immediate
- in_ext_mode  in  2  0=SEXT, 1=ZEXT, 2=UPPER, 3=SEXT_SHL2
- in_dst_mode  in  2  0=RT, 1=RD, 2=LINK, 3=NONE
- in_is_load  in  1  instruction is a load
- flush  in  1  discard the registered instruction and the current input
- out_valid  out  1  registered instruction valid
- out_ready  in  1  EX stage accepts
- out_dst  out  GPR_ADR  selected destination
- out_wr_en  out  1  destination write enable
- out_ext_imm  out  GPR_BIT  extended immediate
- out_is_load  out  1  registered load flag
- bubble_cnt  out  CNT_W  saturating count of hazard bubbles

Behaviour:
Reset (async, rst_n=0):
- All outputs 0; in_ready=0 while rst_n=0.
- Released cleanly mid-transfer: no output register retains old content.

Combinational datapath:
- Immediate extension:
  - SEXT = sign-extend to GPR_BIT.
  - ZEXT = zero-extend.
  - UPPER = {in_imm, (GPR_BIT-IMM_BIT) zeros}.
  - SEXT_SHL2 = sign-extended value shifted left 2, upper bits dropped (mod 2^GPR_BIT).
- Destination select: RT -> in_rt; RD -> in_rd; LINK -> LINK_REG; NONE -> 0.
- wr_en = 1 unless dst_mode=NONE or the selected address is 0.

Hazard:
- hazard = out_valid & out_is_load & out_wr_en & ((in_use_rs & in_rs==out_dst) | (in_use_rt & in_rt==out_dst)).
- Register 0 never hazards, because wr_en=0 for address 0.

in_ready:
- in_ready = ~flush & ~hazard & (~out_valid | out_ready).
- Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.

Register update priority (per clock edge):
1. flush: out_valid<=0; input dropped; bubble_cnt unchanged.
2. Transfer in: all out_* loaded next cycle, out_valid<=1. Latency is 1 cycle.
3. hazard & in_valid & out_ready: out_valid<=0 (bubble); bubble_cnt += 1, saturating at all-ones.
4. Transfer out without input: out_valid<=0.
5. Otherwise: hold. While out_valid & ~out_ready, every out_* is stable.

Boundary and timing rules:
- A hazard produces exactly one bubble cycle. After it, out_valid=0, so the dependent instruction is accepted on the next cycle.
- Hazard with out_ready=0: no bubble is counted until EX accepts the load.
- flush and hazard together: flush wins; no count.
- in_valid=0 during a hazard condition: nothing counted.
- Back-to-back independent instructions with out_ready=1: full throughput, one per cycle.
- in_ready depends on out_ready combinationally; this is intentional (no skid buffer).

Test Plan:
- Reset, then in_imm=16'h8001 with modes 0/1/2/3 in successive cycles, out_ready=1 -> out_ext_imm = 32'hFFFF8001, 32'h00008001, 32'h80010000, 32'hFFFE0004, each one cycle after acceptance.
- dst_mode RT/RD/LINK/NONE with rt=5, rd=9 -> out_dst=5/9/31/0, out_wr_en=1/1/1/0; dst_mode=RT with rt=0 -> out_wr_en=0.
- Load with rt=7, dst=RT, then in_rs=7 with use_rs=1 -> in_ready=0 for one cycle, out_valid=0 for one cycle, bubble_cnt=1, dependent instruction appears on the following cycle.
- Same sequence with use_rs=0, or with the load targeting r0 -> no stall, bubble_cnt stays 0.
- Hold out_ready=0 for 3 cycles with a valid entry -> out_* stable, in_ready=0; then assert flush -> out_valid=0 the next cycle and the concurrent input is dropped.
- CNT_W=2, trigger 5 hazards -> bubble_cnt sticks at 3; assert rst_n=0 mid-stream -> all outputs 0 immediately, without waiting for a clock edge.
